// File: rtl/cdc_hs_pkg.sv
// rtl/cdc_hs_pkg.sv - shared FSM state types and synchronizer depth limits for cdc_hs_b2a
package cdc_hs_pkg;

  typedef enum logic {S_IDLE, S_WAIT} src_state_t;
  typedef enum logic {D_IDLE, D_HOLD} dst_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Out-of-range depths are pulled into the supported window rather than building a broken chain
  function automatic int clamp_stages(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/cdc_toggle_sync.sv
// rtl/cdc_toggle_sync.sv - STAGES-deep flop chain bringing a toggle level into the local clock domain
module cdc_toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_b2a.sv
// rtl/cdc_hs_b2a.sv - clkB->clkA req/ack toggle handshake carrying one DATA_W word per round trip
// Define CDC_HS_PARITY_EN to add an even-parity bit to the held word and a dst_perr output.
module cdc_hs_b2a
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clkA,
  input  logic              rstA,
  input  logic              clkB,
  input  logic              rstB,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              dst_valid,
  output logic [DATA_W-1:0] dst_data,
`ifdef CDC_HS_PARITY_EN
  output logic              dst_perr,
`endif
  input  logic              dst_ready
);

  localparam int STAGES = clamp_stages(SYNC_STAGES);
`ifdef CDC_HS_PARITY_EN
  localparam int HOLD_W = DATA_W + 1;
`else
  localparam int HOLD_W = DATA_W;
`endif

  src_state_t        src_state;
  dst_state_t        dst_state;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              req_tgl, req_sync, req_prev;
  logic              ack_tgl, ack_sync, ack_prev;

`ifdef CDC_HS_PARITY_EN
  assign hold_d = {^src_data, src_data};
`else
  assign hold_d = src_data;
`endif

  // Source side: hold_q is only written in S_IDLE, so it stays frozen for the whole round trip
  always_ff @(posedge clkB or posedge rstB) begin
    if (rstB) begin
      src_state <= S_IDLE;
      src_ready <= 1'b0;
      hold_q    <= '0;
      req_tgl   <= 1'b0;
      ack_prev  <= 1'b0;
    end else begin
      case (src_state)
        S_IDLE: begin
          if (src_valid && src_ready) begin
            hold_q    <= hold_d;
            req_tgl   <= ~req_tgl;
            src_ready <= 1'b0;
            src_state <= S_WAIT;
          end else begin
            src_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (ack_sync != ack_prev) begin
            ack_prev  <= ack_sync;
            src_ready <= 1'b1;
            src_state <= S_IDLE;
          end
        end
        default: src_state <= S_IDLE;
      endcase
    end
  end

  cdc_toggle_sync #(.STAGES(STAGES)) u_req_sync (
    .clk (clkA),
    .rst (rstA),
    .d   (req_tgl),
    .q   (req_sync)
  );

  cdc_toggle_sync #(.STAGES(STAGES)) u_ack_sync (
    .clk (clkB),
    .rst (rstB),
    .d   (ack_tgl),
    .q   (ack_sync)
  );

  // Destination side: hold_q is sampled only once the synchronized request toggle has moved
  always_ff @(posedge clkA or posedge rstA) begin
    if (rstA) begin
      dst_state <= D_IDLE;
      dst_valid <= 1'b0;
      dst_data  <= '0;
      req_prev  <= 1'b0;
      ack_tgl   <= 1'b0;
`ifdef CDC_HS_PARITY_EN
      dst_perr  <= 1'b0;
`endif
    end else begin
      case (dst_state)
        D_IDLE: begin
          if (req_sync != req_prev) begin
            req_prev  <= req_sync;
            dst_data  <= hold_q[DATA_W-1:0];
            dst_valid <= 1'b1;
            dst_state <= D_HOLD;
`ifdef CDC_HS_PARITY_EN
            dst_perr  <= ^hold_q;
`endif
          end
        end
        D_HOLD: begin
          if (dst_ready) begin
            dst_valid <= 1'b0;
            ack_tgl   <= ~ack_tgl;
            dst_state <= D_IDLE;
          end
        end
        default: dst_state <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_hs_b2a.sv
// tb/tb_cdc_hs_b2a.sv - self-checking bench for cdc_hs_b2a with a queue scoreboard and vector table
module tb_cdc_hs_b2a;

  localparam int DW = 8;
  localparam int SS = 2;

  typedef struct {
    logic [DW-1:0] data;
    int            hold;
    logic [DW-1:0] exp_data;
  } vec_t;

  logic          clkA = 1'b0;
  logic          clkB = 1'b0;
  logic          rstA = 1'b1;
  logic          rstB = 1'b1;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic          dst_valid;
  logic [DW-1:0] dst_data;
  logic          dst_ready = 1'b0;
`ifdef CDC_HS_PARITY_EN
  logic          dst_perr;
`endif

  int half_a = 50;
  int half_b = 135;
  int errors = 0;
  int checks = 0;
  int delivered = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  always begin #(half_a); clkA = ~clkA; end
  always begin #(half_b); clkB = ~clkB; end

  cdc_hs_b2a #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clkA      (clkA),
    .rstA      (rstA),
    .clkB      (clkB),
    .rstB      (rstB),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
`ifdef CDC_HS_PARITY_EN
    .dst_perr  (dst_perr),
`endif
    .dst_ready (dst_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every source handshake must come out once, in order, at a destination accept
  always @(negedge clkB)
    if (mon_en && !rstB && src_valid && src_ready) exp_q.push_back(src_data);

  always @(negedge clkA)
    if (mon_en && !rstA && dst_valid && dst_ready) begin
      delivered++;
      if (exp_q.size() == 0) chk("sb_spurious", 32'(dst_data), 32'hFFFF_FFFF);
      else                   chk("sb_word", 32'(dst_data), 32'(exp_q.pop_front()));
    end

  // Returns exactly on the clkB edge that performs the handshake
  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    @(posedge clkB); #10;
    src_valid = 1'b1;
    src_data  = d;
    @(negedge clkB);
    while (!src_ready && n < 2000) begin @(negedge clkB); n++; end
    if (!src_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clkB);
    fork begin #10; src_valid = 1'b0; end join_none
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(posedge clkA); #10; n++; end while (!dst_valid && n < 200);
    if (!dst_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_src_ready(output int m);
    m = 0;
    do begin @(posedge clkB); #10; m++; end while (!src_ready && m < 200);
    if (!src_ready) chk("src_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    src_valid = 1'b0;
    dst_ready = 1'b0;
    rstA = 1'b1;
    rstB = 1'b1;
    repeat (SS + 4) @(posedge clkB);
    #10;
    rstA = 1'b0;
    rstB = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic check_idle(input string name);
    bit bad;
    bad = 1'b0;
    @(posedge clkB); #10;
    chk({name, "_src_ready"}, 32'(src_ready), 32'd1);
    chk({name, "_dst_data"}, 32'(dst_data), 32'd0);
`ifdef CDC_HS_PARITY_EN
    chk({name, "_dst_perr"}, 32'(dst_perr), 32'd0);
`endif
    repeat (100) begin @(posedge clkA); #10; if (dst_valid) bad = 1'b1; end
    chk({name, "_no_spurious"}, 32'(bad), 32'd0);
  endtask

  task automatic run_stream(input int nw, input bit rnd);
    int sent, start;
    sent  = 0;
    start = delivered;
    fork
      begin
        int cb;
        bit hs;
        cb = 0;
        @(posedge clkB); #10;
        src_data  = rnd ? 8'($urandom) : 8'(sent);
        src_valid = 1'b1;
        while (sent < nw && cb < 20000) begin
          @(negedge clkB);
          hs = src_valid && src_ready;
          @(posedge clkB); #10;
          cb++;
          if (hs) begin
            sent++;
            src_data = rnd ? 8'($urandom) : 8'(sent);
          end
          src_valid = (sent < nw) && (!rnd || $urandom_range(3) != 0);
        end
        src_valid = 1'b0;
      end
      begin
        int ca;
        ca = 0;
        while (delivered - start < nw && ca < 40000) begin
          @(posedge clkA); #10;
          ca++;
          dst_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
        end
      end
    join
    chk("stream_count", 32'(delivered - start), 32'(nw));
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t tbl [7];
    int   n, m, d0;
    bit   bad;

    tbl = '{'{8'h00, 0, 8'h00}, '{8'hFF, 3, 8'hFF}, '{8'h55, 0, 8'h55}, '{8'h55, 0, 8'h55},
            '{8'h3C, 50, 8'h3C}, '{8'h3D, 0, 8'h3D}, '{8'h81, 7, 8'h81}};

    do_reset();
    check_idle("reset");

    // Single word: forward and return latency
    dst_ready = 1'b1;
    send(8'hA5);
    wait_valid(n);
    chk("fwd_latency", 32'(n), 32'(SS + 1));
    chk("a5_data", 32'(dst_data), 32'hA5);
`ifdef CDC_HS_PARITY_EN
    chk("a5_perr", 32'(dst_perr), 32'd0);
`endif
    @(posedge clkA);
    fork
      begin #10; chk("a5_pulse", 32'(dst_valid), 32'd0); end
      wait_src_ready(m);
    join
    chk("ret_latency", 32'(m), 32'(SS + 1));

    // Vector table: identical words, backpressure holds
    d0 = delivered;
    for (int i = 0; i < 7; i++) begin
      dst_ready = (tbl[i].hold == 0);
      send(tbl[i].data);
      wait_valid(n);
      chk("tbl_data", 32'(dst_data), 32'(tbl[i].exp_data));
      bad = 1'b0;
      repeat (tbl[i].hold) begin
        @(posedge clkA); #10;
        if (!dst_valid || dst_data !== tbl[i].exp_data || src_ready) bad = 1'b1;
      end
      chk("tbl_backpressure", 32'(bad), 32'd0);
      dst_ready = 1'b1;
      @(posedge clkA); #10;
      chk("tbl_accept_clear", 32'(dst_valid), 32'd0);
      wait_src_ready(m);
    end
    chk("tbl_delivered", 32'(delivered - d0), 32'd7);

    // Back-to-back streams at three clock ratios, then randomized traffic
    run_stream(64, 1'b0);
    half_a = 50;  half_b = 155;
    run_stream(64, 1'b0);
    half_a = 155; half_b = 50;
    run_stream(64, 1'b0);
    run_stream(100, 1'b1);
    half_a = 50;  half_b = 135;
    run_stream(100, 1'b1);

    // Reset with a word parked in D_HOLD / S_WAIT
    dst_ready = 1'b0;
    send(8'h77);
    wait_valid(n);
    chk("pre_reset_word", 32'(dst_data), 32'h77);
    do_reset();
    check_idle("midreset");
    dst_ready = 1'b1;
    send(8'h12);
    wait_valid(n);
    chk("post_reset_data", 32'(dst_data), 32'h12);
    @(posedge clkA);
    wait_src_ready(m);

`ifdef CDC_HS_PARITY_EN
    mon_en = 1'b0;
    dst_ready = 1'b0;
    send(8'h0F);
    #20;
    force dut.hold_q = 9'h00E;
    wait_valid(n);
    chk("perr_flag", 32'(dst_perr), 32'd1);
    chk("perr_data", 32'(dst_data), 32'h0E);
    release dut.hold_q;
    dst_ready = 1'b1;
    @(posedge clkA);
    wait_src_ready(m);
    mon_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
